ks_pluck_sequencer: RTL and testbench
=====================================

Name: ks_pluck_sequencer

Overview:
Step sequencer and pluck arbiter for the Karplus-Strong string core. It stores a short pattern of string periods and times plucks in audio-frame ticks (one per I2S WS frame). It merges those plucks with manual plucks from the SPI register map and hands each one to the KS core with a ready handshake. It sits between the SPI config registers and the KS core's period/pluck inputs.

Parameters:
NUM_STEPS, 8, pattern depth (power of 2)
PERIOD_WIDTH, 10, KS period in Q6.4 (6 integer bits for max length 64, 4 fractional bits)
TEMPO_WIDTH, 16, width of frames-per-step divider
DEFAULT_PERIOD, 10'h200, ks_period value at reset (32.0 samples)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sample_tick  in  1  one-cycle pulse per audio frame
seq_en  in  1  level; 1 = sequencer running
seq_len  in  $clog2(NUM_STEPS)+1  active steps; 0 means NUM_STEPS
tempo_div  in  TEMPO_WIDTH  frames per step; 0 is treated as 1
swing  in  TEMPO_WIDTH  extra frames on odd steps (used only with the macro)
wr_en  in  1  pattern write strobe
wr_addr  in  $clog2(NUM_STEPS)  pattern index
wr_data  in  PERIOD_WIDTH+1  {step_enable, period}
manual_pluck  in  1  level from the SPI register bit; a rising edge requests a pluck
manual_period  in  PERIOD_WIDTH  period for manual plucks
ks_ready  in  1  KS core can accept a pluck
ks_period  out  PERIOD_WIDTH  period presented to the KS core
ks_pluck  out  1  one-cycle pluck strobe
cur_step  out  $clog2(NUM_STEPS)  step index to be played next
running  out  1  sequencer state is RUN
overrun  out  1  sticky; a request was displaced or dropped
clear_overrun  in  1  one-cycle pulse; clears overrun

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - ks_period = DEFAULT_PERIOD.
  - ks_pluck, running, overrun = 0.
  - cur_step = 0.
  - Pattern contents are 0 (all steps disabled).
  - Pending request is cleared and manual_pluck edge history = 0.
  - A reset mid-operation aborts any pending request.
- State machine IDLE/RUN:
  - IDLE -> RUN on seq_en=1: cur_step=0, frame counter = 0, so step 0 fires on the first sample_tick in RUN.
  - RUN -> IDLE on seq_en=0: cur_step=0 and the counter is cleared. A request already pending is still delivered.
- Step timing in RUN, on sample_tick:
  - Counter==0: step boundary.
    - Read pattern[cur_step]. If step_enable=1, raise a sequencer request carrying that period.
    - Reload the counter with eff_div-1, where eff_div = max(tempo_div, 1).
    - cur_step advances, wrapping to 0 after seq_len-1.
  - Counter!=0: decrement.
  - A seq_len change that leaves cur_step >= seq_len wraps cur_step to 0 at the next boundary.
- Request arbitration: a single pending slot holds {valid, period}.
  - A manual rising edge and a sequencer request in the same cycle: manual wins, the sequencer request is dropped and overrun=1.
  - A new request while the slot is valid: the newer request replaces the older one and overrun=1.
- Handshake:
  - When the slot is valid and ks_ready=1, the next cycle has ks_pluck=1 and ks_period = slot period, and the slot is cleared.
  - Latency from a request cycle with ks_ready already high = 1 clk.
  - ks_period holds its value until the next delivered pluck.
  - ks_pluck is never high on two consecutive cycles.
- Pattern write:
  - Synchronous; visible to reads from the next cycle.
  - A write to the step read in the same cycle: the old value is used.
- clear_overrun pulse: clears overrun. If a new overrun event occurs in the same cycle, overrun is set (set wins).

Optional Feature:
KS_SEQ_SWING_EN
- Defined: the reload for odd-indexed steps uses eff_div+swing-1, saturating at all-ones of TEMPO_WIDTH.
- Undefined: the swing port is ignored and all steps use eff_div-1.
- The port exists in both builds.

Decomposition:
- Package ks_seq_pkg holds:
  - width constants: PERIOD_WIDTH, TEMPO_WIDTH, STEP_IDX_W;
  - step entry struct {en, period};
  - state enum {IDLE, RUN}.
- Sub-module ks_seq_tempo_counter: the frame counter with reload, swing add and saturation. It outputs a step_boundary pulse.

Test Plan:
- Reset: rst_n low mid-run with a request pending -> ks_period=0x200, ks_pluck=0, running=0, cur_step=0, no pluck after release.
- Basic sequence: pattern[0..3] = {1,0x200},{0,x},{1,0x100},{1,0x080}, seq_len=4, tempo_div=3, ks_ready=1 -> plucks at ticks 1, 7, 10, 13 with periods 0x200, 0x100, 0x080, 0x200. Step 1 is silent, and step 0 wraps back at tick 13.
- Handshake backpressure: ks_ready=0 across two sequencer boundaries -> overrun=1; raising ks_ready produces one pluck carrying the second period.
- Collision: manual_pluck rises in the same cycle as a step boundary, manual_period=0x300 -> one pluck with 0x300 and overrun=1. clear_overrun then returns overrun to 0.
- Edge params: tempo_div=0, seq_len=0 -> a step fires on every tick and cur_step cycles 0..7.
- Swing (macro on): tempo_div=4, swing=2 -> boundary spacing alternates 4, 6, 4, 6 ticks. Swing=0xFFFF -> the reload saturates at 0xFFFF.

Source files
------------

// File: rtl/ks_seq_pkg.sv
// ks_seq_pkg: shared widths, pattern entry and sequencer state for the KS pluck sequencer
package ks_seq_pkg;
  localparam int NUM_STEPS = 8;
  localparam int PERIOD_WIDTH = 10;
  localparam int TEMPO_WIDTH = 16;
  localparam int STEP_IDX_W = $clog2(NUM_STEPS);
  localparam logic [PERIOD_WIDTH-1:0] DEFAULT_PERIOD = 10'h200;
  typedef struct packed {
    logic en;
    logic [PERIOD_WIDTH-1:0] period;
  } step_t;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/ks_pluck_sequencer_if.sv
// ks_pluck_sequencer_if: pluck handshake between the sequencer (master) and the KS core (slave)
interface ks_pluck_sequencer_if #(parameter int PERIOD_WIDTH = ks_seq_pkg::PERIOD_WIDTH);
  logic ks_ready;
  logic [PERIOD_WIDTH-1:0] ks_period;
  logic ks_pluck;
  modport master (input ks_ready, output ks_period, ks_pluck);
  modport slave (output ks_ready, input ks_period, ks_pluck);
endinterface

// File: rtl/ks_seq_tempo_counter.sv
// ks_seq_tempo_counter: frames-per-step divider with step_boundary pulse; odd-step swing under KS_SEQ_SWING_EN
module ks_seq_tempo_counter #(
  parameter int TEMPO_WIDTH = ks_seq_pkg::TEMPO_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   active,
  input  logic                   sample_tick,
  input  logic                   odd_step,
  input  logic [TEMPO_WIDTH-1:0] tempo_div,
  input  logic [TEMPO_WIDTH-1:0] swing,
  output logic                   step_boundary
);
  logic [TEMPO_WIDTH-1:0] cnt, eff_m1, reload;
  assign eff_m1 = tempo_div == '0 ? '0 : tempo_div - 1;
`ifdef KS_SEQ_SWING_EN
  logic [TEMPO_WIDTH:0] swung;
  assign swung = {1'b0, eff_m1} + {1'b0, swing};
  assign reload = odd_step ? (swung[TEMPO_WIDTH] ? '1 : swung[TEMPO_WIDTH-1:0]) : eff_m1;
`else
  logic unused_swing;
  assign unused_swing = ^{swing, odd_step};
  assign reload = eff_m1;
`endif
  assign step_boundary = active & sample_tick & (cnt == '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (!active) cnt <= '0;
    else if (sample_tick) cnt <= cnt == '0 ? reload : cnt - 1;
endmodule

// File: rtl/ks_pluck_sequencer.sv
// ks_pluck_sequencer: step pattern + manual pluck arbiter feeding the KS core; KS_SEQ_SWING_EN enables odd-step swing
module ks_pluck_sequencer #(
  parameter int NUM_STEPS = ks_seq_pkg::NUM_STEPS,
  parameter int PERIOD_WIDTH = ks_seq_pkg::PERIOD_WIDTH,
  parameter int TEMPO_WIDTH = ks_seq_pkg::TEMPO_WIDTH,
  parameter logic [PERIOD_WIDTH-1:0] DEFAULT_PERIOD = ks_seq_pkg::DEFAULT_PERIOD
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           sample_tick,
  input  logic                           seq_en,
  input  logic [$clog2(NUM_STEPS):0]     seq_len,
  input  logic [TEMPO_WIDTH-1:0]         tempo_div,
  input  logic [TEMPO_WIDTH-1:0]         swing,
  input  logic                           wr_en,
  input  logic [$clog2(NUM_STEPS)-1:0]   wr_addr,
  input  logic [PERIOD_WIDTH:0]          wr_data,
  input  logic                           manual_pluck,
  input  logic [PERIOD_WIDTH-1:0]        manual_period,
  output logic [$clog2(NUM_STEPS)-1:0]   cur_step,
  output logic                           running,
  output logic                           overrun,
  input  logic                           clear_overrun,
  ks_pluck_sequencer_if.master           ks
);
  import ks_seq_pkg::*;
  localparam int SW = $clog2(NUM_STEPS);
  state_t state;
  logic [PERIOD_WIDTH:0] pattern [NUM_STEPS];
  logic [PERIOD_WIDTH:0] step_now;
  logic [SW:0] len_eff;
  logic [SW-1:0] next_step;
  logic active, boundary, manual_q, man_edge, seq_req, req_v, can_go, go, ovr_ev;
  logic slot_v, slot_v_n, pluck_r;
  logic [PERIOD_WIDTH-1:0] slot_p, slot_p_n, req_p, go_p, period_r;
  ks_seq_tempo_counter #(.TEMPO_WIDTH(TEMPO_WIDTH)) u_tempo (
    .clk           (clk),
    .rst_n         (rst_n),
    .active        (active),
    .sample_tick   (sample_tick),
    .odd_step      (cur_step[0]),
    .tempo_div     (tempo_div),
    .swing         (swing),
    .step_boundary (boundary)
  );
  assign running = state == RUN;
  assign ks.ks_pluck = pluck_r;
  assign ks.ks_period = period_r;
  always_comb begin
    active = running & seq_en;
    len_eff = seq_len == '0 ? (SW+1)'(NUM_STEPS) : seq_len;
    next_step = ({1'b0, cur_step} + 1 >= len_eff) ? '0 : cur_step + 1;
    step_now = pattern[cur_step];
    seq_req = boundary & step_now[PERIOD_WIDTH];
    man_edge = manual_pluck & ~manual_q;
    req_v = man_edge | seq_req;
    req_p = man_edge ? manual_period : step_now[PERIOD_WIDTH-1:0];
    // pluck spacing guard: a delivery cycle can never be followed by another
    can_go = ks.ks_ready & ~pluck_r;
    go = can_go & (slot_v | req_v);
    go_p = slot_v ? slot_p : req_p;
    slot_v_n = slot_v ? (~can_go | req_v) : (req_v & ~can_go);
    slot_p_n = req_v ? req_p : slot_p;
    ovr_ev = (man_edge & seq_req) | (slot_v & ~can_go & req_v);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cur_step <= '0;
      manual_q <= 1'b0;
      slot_v <= 1'b0;
      slot_p <= '0;
      pluck_r <= 1'b0;
      period_r <= DEFAULT_PERIOD;
      overrun <= 1'b0;
      for (int i = 0; i < NUM_STEPS; i++) pattern[i] <= '0;
    end else begin
      state <= seq_en ? RUN : IDLE;
      cur_step <= !active ? '0 : boundary ? next_step : cur_step;
      manual_q <= manual_pluck;
      slot_v <= slot_v_n;
      slot_p <= slot_p_n;
      pluck_r <= go;
      if (go) period_r <= go_p;
      overrun <= ovr_ev | (overrun & ~clear_overrun);
      if (wr_en) pattern[wr_addr] <= wr_data;
    end
endmodule

// File: tb/tb_ks_pluck_sequencer.sv
// tb_ks_pluck_sequencer: directed plan scenarios plus random traffic against a tick/queue reference model
module tb_ks_pluck_sequencer;
  import ks_seq_pkg::*;
  localparam int SW = STEP_IDX_W;
  logic clk = 0, rst_n = 0, sample_tick = 0, seq_en = 0, wr_en = 0;
  logic manual_pluck = 0, clear_overrun = 0, ks_ready = 0;
  logic [SW:0] seq_len = 0;
  logic [TEMPO_WIDTH-1:0] tempo_div = 0, swing = 0;
  logic [SW-1:0] wr_addr = 0;
  logic [PERIOD_WIDTH:0] wr_data = 0;
  logic [PERIOD_WIDTH-1:0] manual_period = 0;
  logic [SW-1:0] cur_step;
  logic running, overrun;
  ks_pluck_sequencer_if #(.PERIOD_WIDTH(PERIOD_WIDTH)) ks();
  assign ks.ks_ready = ks_ready;
  ks_pluck_sequencer dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .seq_en(seq_en),
    .seq_len(seq_len), .tempo_div(tempo_div), .swing(swing), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .manual_pluck(manual_pluck),
    .manual_period(manual_period), .cur_step(cur_step), .running(running),
    .overrun(overrun), .clear_overrun(clear_overrun), .ks(ks.master)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_bad = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // reference model: absolute tick numbers for step firing, a request list for the slot
  step_t pat [NUM_STEPS];
  int q [$];
  bit m_run = 0, m_man_q = 0, e_pluck = 0, e_ov = 0;
  int e_period = DEFAULT_PERIOD, e_step = 0;
  longint tick_no = 0, next_fire = 0;
  function automatic longint spacing(int s);
    longint e = tempo_div == 0 ? 1 : longint'(tempo_div);
`ifdef KS_SEQ_SWING_EN
    if (s % 2 == 1) begin
      e += longint'(swing);
      if (e > 65536) e = 65536;
    end
`endif
    return e;
  endfunction
  always @(posedge clk or negedge rst_n) begin : model
    bit fire, sreq, medge, ev;
    int played, len;
    int lst [$];
    if (!rst_n) begin
      for (int i = 0; i < NUM_STEPS; i++) pat[i] = '0;
      q = {};
      m_run = 0; m_man_q = 0; e_pluck = 0; e_ov = 0;
      e_period = DEFAULT_PERIOD; e_step = 0; tick_no = 0; next_fire = 0;
    end else begin
      fire = 0; played = 0;
      if (m_run && seq_en && sample_tick) begin
        if (tick_no == next_fire) begin
          fire = 1; played = e_step;
          next_fire = tick_no + spacing(e_step);
          len = seq_len == 0 ? NUM_STEPS : int'(seq_len);
          e_step = (e_step + 1 >= len) ? 0 : e_step + 1;
        end
        tick_no++;
      end
      if (!(m_run && seq_en)) begin tick_no = 0; next_fire = 0; e_step = 0; end
      m_run = seq_en;
      sreq = fire && pat[played].en;
      medge = manual_pluck && !m_man_q;
      m_man_q = manual_pluck;
      ev = medge && sreq;
      lst = q;
      if (medge) lst.push_back(int'(manual_period));
      else if (sreq) lst.push_back(int'(pat[played].period));
      if (ks_ready && !e_pluck && lst.size() > 0) begin
        e_pluck = 1; e_period = lst.pop_front();
      end else e_pluck = 0;
      if (lst.size() > 1) begin
        ev = 1;
        while (lst.size() > 1) void'(lst.pop_front());
      end
      q = lst;
      e_ov = ev ? 1 : clear_overrun ? 0 : e_ov;
      if (wr_en) pat[wr_addr] = wr_data;
    end
  end
  int n_pl = 0, last_p = 0;
  always @(negedge clk) if (rst_n) begin
    chk("pluck", ks.ks_pluck, e_pluck);
    chk("period", ks.ks_period, e_period);
    chk("cur_step", cur_step, e_step);
    chk("running", running, m_run);
    chk("overrun", overrun, e_ov);
    if (ks.ks_pluck) begin n_pl++; last_p = ks.ks_period; end
  end
  task automatic cyc(); @(posedge clk); @(negedge clk); endtask
  task automatic clr_inputs();
    sample_tick = 0; seq_en = 0; wr_en = 0; manual_pluck = 0; clear_overrun = 0;
    ks_ready = 0; seq_len = 0; tempo_div = 0; swing = 0; manual_period = 0;
  endtask
  task automatic do_reset();
    #2 rst_n = 0;
    clr_inputs();
    @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
  endtask
  task automatic wr(int a, int en, int p);
    wr_en = 1; wr_addr = a[SW-1:0]; wr_data = {en[0], p[PERIOD_WIDTH-1:0]};
    cyc();
    wr_en = 0;
  endtask
  task automatic tk(int gap);
    sample_tick = 1;
    cyc();
    sample_tick = 0;
    repeat (gap) cyc();
  endtask
  int n0;
  initial begin
    @(negedge clk);
    do_reset();
    // basic sequence: plucks at ticks 1,7,10,13
    wr(0, 1, 'h200); wr(1, 0, 0); wr(2, 1, 'h100); wr(3, 1, 'h080);
    seq_len = 4; tempo_div = 3; ks_ready = 1; seq_en = 1;
    cyc();
    n0 = n_pl;
    repeat (13) tk(1);
    chk("basic_cnt", n_pl - n0, 4);
    chk("basic_last", last_p, 'h200);
    chk("basic_step", cur_step, 1);
    seq_en = 0; cyc(); cyc();
    // backpressure across two boundaries
    do_reset();
    wr(0, 1, 'h111); wr(1, 1, 'h222);
    seq_len = 2; tempo_div = 1; seq_en = 1;
    cyc();
    n0 = n_pl;
    tk(1); tk(1);
    seq_en = 0;
    cyc();
    chk("bp_ovr", overrun, 1);
    chk("bp_none", n_pl - n0, 0);
    ks_ready = 1;
    repeat (4) cyc();
    chk("bp_cnt", n_pl - n0, 1);
    chk("bp_period", last_p, 'h222);
    // manual edge colliding with a step boundary
    do_reset();
    wr(0, 1, 'h100);
    seq_len = 1; tempo_div = 10; ks_ready = 1; seq_en = 1;
    cyc();
    manual_period = 'h300; manual_pluck = 1; sample_tick = 1;
    cyc();
    sample_tick = 0;
    chk("col_pluck", ks.ks_pluck, 1);
    chk("col_period", ks.ks_period, 'h300);
    chk("col_ovr", overrun, 1);
    cyc();
    clear_overrun = 1; cyc(); clear_overrun = 0;
    chk("col_clr", overrun, 0);
    manual_pluck = 0;
    // tempo_div=0, seq_len=0: one step per tick over all steps
    do_reset();
    for (int i = 0; i < NUM_STEPS; i++) wr(i, 1, 'h40 + i);
    ks_ready = 1; seq_en = 1;
    cyc();
    repeat (3) tk(1);
    chk("edge_step3", cur_step, 3);
    repeat (5) tk(1);
    chk("edge_wrap", cur_step, 0);
`ifdef KS_SEQ_SWING_EN
    begin
      int fires [$];
      do_reset();
      wr(0, 1, 'h10); wr(1, 1, 'h20);
      seq_len = 2; tempo_div = 4; swing = 2; ks_ready = 1; seq_en = 1;
      cyc();
      for (int i = 1; i <= 20; i++) begin
        sample_tick = 1; cyc(); sample_tick = 0;
        if (ks.ks_pluck) fires.push_back(i);
        cyc();
      end
      chk("swing_n", fires.size(), 4);
      for (int i = 0; i < 4 && i < fires.size(); i++) chk("swing_tick", fires[i], i == 0 ? 1 : i == 1 ? 5 : i == 2 ? 11 : 15);
      do_reset();
      wr(0, 1, 'h10); wr(1, 1, 'h20);
      seq_len = 2; tempo_div = 4; swing = 16'hFFFF; ks_ready = 1; seq_en = 1;
      cyc();
      repeat (5) tk(1);
      n0 = n_pl;
      repeat (30) tk(1);
      chk("swing_sat", n_pl - n0, 0);
    end
`endif
    // reset mid-run with a request pending
    do_reset();
    wr(0, 1, 'h155);
    seq_len = 1; tempo_div = 2; seq_en = 1;
    cyc();
    tk(1);
    #2 rst_n = 0;
    #1;
    chk("rst_period", ks.ks_period, DEFAULT_PERIOD);
    chk("rst_pluck", ks.ks_pluck, 0);
    chk("rst_running", running, 0);
    chk("rst_step", cur_step, 0);
    chk("rst_ovr", overrun, 0);
    clr_inputs();
    @(negedge clk);
    #2 rst_n = 1;
    ks_ready = 1;
    @(negedge clk);
    n0 = n_pl;
    repeat (4) cyc();
    chk("rst_nopluck", n_pl - n0, 0);
    // random traffic
    for (int i = 0; i < NUM_STEPS; i++) wr(i, int'($urandom_range(0, 1)), int'($urandom));
    seq_len = 0; tempo_div = 2; seq_en = 1;
    for (int c = 0; c < 3000; c++) begin
      sample_tick = $urandom_range(0, 2) == 0;
      if ($urandom_range(0, 199) == 0) seq_en = ~seq_en;
      ks_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 9) == 0) manual_pluck = ~manual_pluck;
      manual_period = PERIOD_WIDTH'($urandom);
      wr_en = $urandom_range(0, 7) == 0;
      wr_addr = SW'($urandom);
      wr_data = (PERIOD_WIDTH+1)'($urandom);
      clear_overrun = $urandom_range(0, 19) == 0;
      if ($urandom_range(0, 299) == 0) tempo_div = TEMPO_WIDTH'($urandom_range(0, 3));
      if ($urandom_range(0, 399) == 0) seq_len = (SW+1)'($urandom_range(0, NUM_STEPS));
      if ($urandom_range(0, 99) == 0) swing = TEMPO_WIDTH'($urandom_range(0, 2));
      cyc();
    end
    clr_inputs();
    cyc();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
